// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, latencies and D-stage decode constants for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } mdop_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // SPECIAL-opcode funct codes the D-stage controller decodes into md_use_D
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational product and quotient/remainder from latched operands
module mdu_core
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        wr_en
);

    logic        signed_op;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Work on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign neg_a     = signed_op & a[31];
    assign neg_b     = signed_op & b[31];
    assign mag_a     = neg_a ? (~a + 32'd1) : a;
    assign mag_b     = neg_b ? (~b + 32'd1) : b;

    assign prod_mag  = {32'd0, mag_a} * {32'd0, mag_b};
    assign prod      = (neg_a ^ neg_b) ? (~prod_mag + 64'd1) : prod_mag;

    assign q_mag     = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign r_mag     = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign quot      = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem       = neg_a ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        wr_en  = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                hi_res = prod[63:32];
                lo_res = prod[31:0];
                wr_en  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                hi_res = rem;
                lo_res = quot;
                wr_en  = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - E-stage multiply/divide unit with HI/LO registers and F/D stall request
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             res_wr;
    logic             long_start;
    logic             accept;
    logic             last_cycle;

    assign long_start = start & is_long_op(mdop);
    assign accept     = long_start & (state == ST_IDLE);
    assign last_cycle = (state == ST_RUN) && (cnt == CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)     state_nxt = ST_RUN;
            ST_RUN:  if (last_cycle) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

    // Raised in the start cycle itself so the D instruction never slips past a fresh op
    assign stall_md = md_use_D & (busy | long_start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= MD_NONE;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                op_q <= mdop;
                a_q  <= rs_val;
                b_q  <= rt_val;
                cnt  <= ((mdop == MD_MULT) || (mdop == MD_MULTU)) ? MULT_LD : DIV_LD;
            end else if (start && (mdop == MD_MTHI)) begin
                hi <= rs_val;
            end else if (start && (mdop == MD_MTLO)) begin
                lo <= rs_val;
            end
        end else begin
            cnt <= cnt - CNT_ONE;
            if (last_cycle && res_wr) begin
                hi <= hi_res;
                lo <= lo_res;
            end
        end
    end

    mdu_core u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .wr_en  (res_wr)
    );

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking bench for mdu_unit with a behavioural HI/LO model
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdop     (mdop),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result {write, hi, lo} from plain 64-bit integer arithmetic
    function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return {1'b1, p};
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b1, p};
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) return 65'd0;
                if (op == MD_DIV) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'd0, a});
                    sb = longint'({32'd0, b});
                end
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            default: return 65'd0;
        endcase
    endfunction

    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_wr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            p_wr   <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && p_wr) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start) begin
            case (mdop)
                MD_MULT, MD_MULTU: begin
                    m_left <= MULT_N;
                    {p_wr, p_hi, p_lo} <= ref_result(mdop, rs_val, rt_val);
                end
                MD_DIV, MD_DIVU: begin
                    m_left <= DIV_N;
                    {p_wr, p_hi, p_lo} <= ref_result(mdop, rs_val, rt_val);
                end
                MD_MTHI: m_hi <= rs_val;
                MD_MTLO: m_lo <= rs_val;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_busy", busy, m_left > 0);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
            check("cyc_stall", stall_md, md_use_D &&
                  (m_left > 0 || (start && mdop inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})));
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(start && busy))
            else begin
                tests_failed++;
                $display("FAIL start_while_busy: start=%0b busy=%0b", start, busy);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d, input int n, input string name);
        int busy_cycles;
        busy_cycles = 0;
        start = 1'b1; mdop = op; rs_val = a; rt_val = b; md_use_D = use_d;
        #1;
        if (use_d) check({name, "_stall_start"}, stall_md, 1);
        tick;
        start = 1'b0; mdop = MD_NONE; rs_val = $urandom; rt_val = $urandom;
        while (busy && busy_cycles < 40) begin
            if (use_d) check({name, "_stall_busy"}, stall_md, 1);
            busy_cycles++;
            tick;
        end
        check({name, "_busy_cycles"}, busy_cycles, n);
        if (use_d) check({name, "_stall_idle"}, stall_md, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; mdop = MD_NONE; rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b1;
        tick; tick;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_stall", stall_md, 0);
        reset = 1'b0; md_use_D = 1'b0;
        tick;

        run_long(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, MULT_N, "mult");
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        run_long(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, MULT_N, "multu");
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        run_long(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, DIV_N, "div");
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        run_long(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, DIV_N, "div_ovf");
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);
        run_long(MD_DIVU, 32'd7, 32'd2, 1'b0, DIV_N, "divu");
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);
        run_long(MD_DIV, 32'd5, 32'd0, 1'b0, DIV_N, "div0");
        check("div0_lo", lo, 32'd3);
        check("div0_hi", hi, 32'd1);

        start = 1'b1; mdop = MD_MTHI; rs_val = 32'h12345678;
        tick;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", busy, 0);
        mdop = MD_MTLO; rs_val = 32'h9ABCDEF0;
        tick;
        start = 1'b0; mdop = MD_NONE;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", busy, 0);
        tick;

        run_long(MD_MULT, 32'd7, 32'd9, 1'b1, MULT_N, "stall");
        check("stall_lo", lo, 32'd63);
        check("stall_hi", hi, 32'd0);
        md_use_D = 1'b0;
        tick;

        start = 1'b1; mdop = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
        tick;
        start = 1'b0; mdop = MD_NONE;
        tick; tick;
        check("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        tick;
        reset = 1'b0;
        tick;
        run_long(MD_MULT, 32'd2, 32'd3, 1'b0, MULT_N, "after_rst");
        check("after_rst_lo", lo, 32'd6);
        check("after_rst_hi", hi, 32'd0);
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
